sha3_miner_csr: RTL and testbench

Avalon-MM slave register block directly upstream of the SHA3-256 miner engine. It holds header, difficulty, start nonce and control words, and drives them to the engine. It captures the engine's solution, status and IRQ for HPS software. It also sequences a clean run restart and latches a software-visible interrupt.

---
 rtl/sha3_miner_csr_pkg.sv | 36 +++
 rtl/sha3_miner_csr_restart.sv | 55 +++++
 rtl/sha3_miner_csr.sv | 196 +++++++++++++++++++
 tb/tb_sha3_miner_csr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_miner_csr_pkg.sv
// Shared definitions for the SHA3 miner CSR block: register map, IRQCTL bits,
// control field positions and restart FSM states.
package sha3_miner_csr_pkg;

    localparam logic [4:0] ADDR_HEADER0    = 5'h00;
    localparam logic [4:0] ADDR_HEADER7    = 5'h07;
    localparam logic [4:0] ADDR_DIFF0      = 5'h08;
    localparam logic [4:0] ADDR_DIFF7      = 5'h0F;
    localparam logic [4:0] ADDR_NONCE_LO   = 5'h10;
    localparam logic [4:0] ADDR_NONCE_HI   = 5'h11;
    localparam logic [4:0] ADDR_CONTROL    = 5'h12;
    localparam logic [4:0] ADDR_STATUS     = 5'h13;
    localparam logic [4:0] ADDR_SOL_LO     = 5'h14;
    localparam logic [4:0] ADDR_SOL_HI     = 5'h15;
    localparam logic [4:0] ADDR_IRQCTL     = 5'h16;
    localparam logic [4:0] ADDR_ID         = 5'h17;
    localparam logic [4:0] ADDR_HASHCNT_LO = 5'h18;
    localparam logic [4:0] ADDR_HASHCNT_HI = 5'h19;

    localparam int unsigned IRQCTL_PENDING = 0;
    localparam int unsigned IRQCTL_ENABLE  = 1;
    localparam int unsigned IRQCTL_RESTART = 2;

    localparam int unsigned CTL_RUN      = 0;
    localparam int unsigned CTL_TEST     = 1;
    localparam int unsigned CTL_HALT     = 2;
    localparam int unsigned CTL_PADL_LSB = 3;
    localparam int unsigned CTL_PADF_LSB = 11;
    localparam int unsigned CTL_W        = 19;

    typedef enum logic {
        RST_IDLE = 1'b0,
        RST_DROP = 1'b1
    } restart_state_e;

endpackage

// File: rtl/sha3_miner_csr_restart.sv
// Restart sequencer: holds run_mask low for RESTART_CYCLES cycles after a
// trigger so the miner's control synchroniser sees a clean run drop.
module sha3_miner_csr_restart
    import sha3_miner_csr_pkg::*;
#(
    parameter int unsigned RESTART_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic run_mask
);

    localparam int unsigned CNT_W = $clog2(RESTART_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_CYCLES - 1);

    restart_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_mask = 1'b1;
        case (state_q)
            RST_IDLE: begin
                if (trigger) begin
                    state_d = RST_DROP;
                    cnt_d   = CNT_LOAD;
                end
            end
            RST_DROP: begin
                run_mask = 1'b0;
                // A fresh trigger restarts the full drop window.
                if (trigger) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/sha3_miner_csr.sv
// Avalon-MM CSR block feeding the SHA3-256 miner engine. Optional 64-bit
// hash cycle counter at 0x18/0x19 is enabled by HASH_CYCLE_COUNTER_EN.
module sha3_miner_csr
    import sha3_miner_csr_pkg::*;
#(
    parameter int unsigned RESTART_CYCLES = 4,
    parameter logic [31:0] ID_VALUE       = 32'h5A3A0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   avs_address,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    input  logic         avs_read,
    output logic [31:0]  avs_readdata,
    output logic         avs_readdatavalid,
    output logic [255:0] header,
    output logic [255:0] difficulty,
    output logic [63:0]  start_nonce,
    output logic [18:0]  control,
    input  logic [63:0]  solution,
    input  logic [6:0]   status,
    input  logic         miner_irq,
    output logic         irq
);

    logic [255:0]     header_q, header_d;
    logic [255:0]     difficulty_q, difficulty_d;
    logic [63:0]      nonce_q, nonce_d;
    logic [CTL_W-1:0] ctl_q, ctl_d;
    logic [31:0]      sol_hold_q, sol_hold_d;
    logic             pending_q, pending_d;
    logic             enable_q, enable_d;
    logic             irq_q, irq_d;
    logic             miner_irq_d1_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;

    logic [31:0]      rmux;
    logic             wr_irqctl;
    logic             restart_trig;
    logic             irq_edge;
    logic             run_mask;
    logic [7:0]       word_sel;

`ifdef HASH_CYCLE_COUNTER_EN
    logic [63:0]      hashcnt_q, hashcnt_d;
    logic [31:0]      hashcnt_hold_q, hashcnt_hold_d;
`endif

    assign word_sel     = {avs_address[2:0], 5'b0};
    assign wr_irqctl    = avs_write && (avs_address == ADDR_IRQCTL);
    assign restart_trig = wr_irqctl && avs_writedata[IRQCTL_RESTART];
    assign irq_edge     = miner_irq && !miner_irq_d1_q;

    sha3_miner_csr_restart #(
        .RESTART_CYCLES(RESTART_CYCLES)
    ) u_restart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (restart_trig),
        .run_mask(run_mask)
    );

    always_comb begin
        header_d     = header_q;
        difficulty_d = difficulty_q;
        nonce_d      = nonce_q;
        ctl_d        = ctl_q;
        enable_d     = enable_q;
        if (avs_write) begin
            case (avs_address[4:3])
                2'b00: header_d[word_sel +: 32]     = avs_writedata;
                2'b01: difficulty_d[word_sel +: 32] = avs_writedata;
                default: begin
                    case (avs_address)
                        ADDR_NONCE_LO: nonce_d[31:0]  = avs_writedata;
                        ADDR_NONCE_HI: nonce_d[63:32] = avs_writedata;
                        ADDR_CONTROL:  ctl_d          = avs_writedata[CTL_W-1:0];
                        ADDR_IRQCTL:   enable_d       = avs_writedata[IRQCTL_ENABLE];
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Edge set is applied last so it beats a simultaneous W1C or restart clear.
    always_comb begin
        pending_d = pending_q;
        if (wr_irqctl && avs_writedata[IRQCTL_PENDING]) pending_d = 1'b0;
        if (restart_trig) pending_d = 1'b0;
        if (irq_edge) pending_d = 1'b1;
        irq_d = pending_q && enable_q;
    end

`ifdef HASH_CYCLE_COUNTER_EN
    always_comb begin
        hashcnt_d = hashcnt_q;
        if (avs_write && (avs_address == ADDR_HASHCNT_LO)) begin
            hashcnt_d = '0;
        end else if (status[1] && !miner_irq) begin
            hashcnt_d = hashcnt_q + 64'd1;
        end
    end
`endif

    always_comb begin
        rmux       = '0;
        sol_hold_d = sol_hold_q;
`ifdef HASH_CYCLE_COUNTER_EN
        hashcnt_hold_d = hashcnt_hold_q;
`endif
        case (avs_address[4:3])
            2'b00: rmux = header_q[word_sel +: 32];
            2'b01: rmux = difficulty_q[word_sel +: 32];
            default: begin
                case (avs_address)
                    ADDR_NONCE_LO: rmux = nonce_q[31:0];
                    ADDR_NONCE_HI: rmux = nonce_q[63:32];
                    ADDR_CONTROL:  rmux = {{(32-CTL_W){1'b0}}, ctl_q};
                    ADDR_STATUS:   rmux = {25'b0, status};
                    ADDR_SOL_LO:   begin
                        rmux = solution[31:0];
                        if (avs_read) sol_hold_d = solution[63:32];
                    end
                    ADDR_SOL_HI:   rmux = sol_hold_q;
                    ADDR_IRQCTL:   rmux = {29'b0, 1'b0, enable_q, pending_q};
                    ADDR_ID:       rmux = ID_VALUE;
`ifdef HASH_CYCLE_COUNTER_EN
                    ADDR_HASHCNT_LO: begin
                        rmux = hashcnt_q[31:0];
                        if (avs_read) hashcnt_hold_d = hashcnt_q[63:32];
                    end
                    ADDR_HASHCNT_HI: rmux = hashcnt_hold_q;
`endif
                    default: rmux = '0;
                endcase
            end
        endcase
        rdata_d = avs_read ? rmux : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_q       <= '0;
            difficulty_q   <= '0;
            nonce_q        <= '0;
            ctl_q          <= '0;
            sol_hold_q     <= '0;
            pending_q      <= 1'b0;
            enable_q       <= 1'b0;
            irq_q          <= 1'b0;
            miner_irq_d1_q <= 1'b0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            header_q       <= header_d;
            difficulty_q   <= difficulty_d;
            nonce_q        <= nonce_d;
            ctl_q          <= ctl_d;
            sol_hold_q     <= sol_hold_d;
            pending_q      <= pending_d;
            enable_q       <= enable_d;
            irq_q          <= irq_d;
            miner_irq_d1_q <= miner_irq;
            rdata_q        <= rdata_d;
            rvalid_q       <= avs_read;
        end
    end

`ifdef HASH_CYCLE_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hashcnt_q      <= '0;
            hashcnt_hold_q <= '0;
        end else begin
            hashcnt_q      <= hashcnt_d;
            hashcnt_hold_q <= hashcnt_hold_d;
        end
    end
`endif

    always_comb begin
        control          = ctl_q;
        control[CTL_RUN] = ctl_q[CTL_RUN] & run_mask;
    end

    assign header            = header_q;
    assign difficulty        = difficulty_q;
    assign start_nonce       = nonce_q;
    assign irq               = irq_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Directed self-checking bench for sha3_miner_csr (default RESTART_CYCLES=4).
module tb_sha3_miner_csr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   avs_address;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic         avs_read;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic [255:0] header;
    logic [255:0] difficulty;
    logic [63:0]  start_nonce;
    logic [18:0]  control;
    logic [63:0]  solution;
    logic [6:0]   status;
    logic         miner_irq;
    logic         irq;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    sha3_miner_csr #(
        .RESTART_CYCLES(4),
        .ID_VALUE      (32'h5A3A0001)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_read         (avs_read),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .header           (header),
        .difficulty       (difficulty),
        .start_nonce      (start_nonce),
        .control          (control),
        .solution         (solution),
        .status           (status),
        .miner_irq        (miner_irq),
        .irq              (irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    initial begin
        rst_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; solution = '0; status = '0; miner_irq = 1'b0;
        repeat (3) tick();
        chk("rst_header", header[63:0] | header[255:192], 64'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_control", {45'b0, control}, 64'h0);
        chk("rst_irq_rvalid", {62'b0, irq, avs_readdatavalid}, 64'h0);
        chk("rst_nonce_diff", start_nonce | difficulty[63:0], 64'h0);

        // ID read with exact one-cycle latency
        avs_address = 5'h17; avs_read = 1'b1;
        chk("id_valid_before", {63'b0, avs_readdatavalid}, 64'h0);
        tick();
        avs_read = 1'b0;
        chk("id_valid", {63'b0, avs_readdatavalid}, 64'h1);
        chk("id_data", {32'b0, avs_readdata}, 64'h5A3A0001);
        tick();
        chk("id_valid_after", {63'b0, avs_readdatavalid}, 64'h0);

        // Header / difficulty / nonce / control
        wr(5'h00, 32'h11223344);
        wr(5'h07, 32'hAABBCCDD);
        rd(5'h00, rd_val); chk("hdr0_rd", {32'b0, rd_val}, 64'h11223344);
        rd(5'h07, rd_val); chk("hdr7_rd", {32'b0, rd_val}, 64'hAABBCCDD);
        chk("hdr0_out", {32'b0, header[31:0]}, 64'h11223344);
        chk("hdr7_out", {32'b0, header[255:224]}, 64'hAABBCCDD);
        wr(5'h0A, 32'hCAFEF00D);
        chk("diff2_out", {32'b0, difficulty[95:64]}, 64'hCAFEF00D);
        wr(5'h11, 32'h01020304);
        chk("nonce_out", start_nonce, 64'h01020304_00000000);
        wr(5'h12, 32'hFFFFFFFF);
        rd(5'h12, rd_val); chk("ctl_rd_mask", {32'b0, rd_val}, 64'h0007FFFF);
        chk("ctl_out", {45'b0, control}, 64'h7FFFF);

        // Simultaneous read+write returns pre-write value
        avs_address = 5'h10; avs_writedata = 32'h12345678;
        avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0;
        chk("rw_old", {32'b0, avs_readdata}, 64'h0);
        rd(5'h10, rd_val); chk("rw_new", {32'b0, rd_val}, 64'h12345678);

        // Unmapped addresses
        wr(5'h1F, 32'hDEADBEEF);
        rd(5'h1F, rd_val); chk("unmapped_1f", {32'b0, rd_val}, 64'h0);
        rd(5'h1A, rd_val); chk("unmapped_1a", {32'b0, rd_val}, 64'h0);
`ifndef HASH_CYCLE_COUNTER_EN
        rd(5'h18, rd_val); chk("hashcnt_off", {32'b0, rd_val}, 64'h0);
`endif

        // Status and coherent solution read
        status = 7'h55;
        rd(5'h13, rd_val); chk("status_rd", {32'b0, rd_val}, 64'h55);
        status = 7'h00;
        solution = 64'h00000001_FFFFFFFF;
        rd(5'h14, rd_val); chk("sol_lo", {32'b0, rd_val}, 64'hFFFFFFFF);
        solution = 64'h00000002_00000000;
        rd(5'h15, rd_val); chk("sol_hi_hold", {32'b0, rd_val}, 64'h1);

        // IRQ: enable, rising edge, registered output
        wr(5'h16, 32'h2);
        miner_irq = 1'b1;
        tick();
        chk("irq_1cyc", {63'b0, irq}, 64'h0);
        tick();
        chk("irq_2cyc", {63'b0, irq}, 64'h1);
        rd(5'h16, rd_val); chk("irqctl_pend", {32'b0, rd_val}, 64'h3);
        wr(5'h16, 32'h3);
        tick();
        chk("irq_cleared", {63'b0, irq}, 64'h0);
        rd(5'h16, rd_val); chk("irqctl_w1c", {32'b0, rd_val}, 64'h2);

        // W1C colliding with a new edge: set wins
        miner_irq = 1'b0;
        tick();
        miner_irq = 1'b1;
        wr(5'h16, 32'h3);
        rd(5'h16, rd_val); chk("w1c_vs_edge", {32'b0, rd_val}, 64'h3);
        chk("w1c_vs_edge_irq", {63'b0, irq}, 64'h1);

        // Restart with control=1; pending is set beforehand and must clear
        wr(5'h12, 32'h1);
        chk("run_idle", {45'b0, control}, 64'h1);
        wr(5'h16, 32'h4);
        avs_address = 5'h12; avs_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drop_run%0d", i), {63'b0, control[0]}, 64'h0);
            tick();
            chk($sformatf("drop_ctlrd%0d", i), {32'b0, avs_readdata}, 64'h1);
        end
        avs_read = 1'b0;
        chk("run_restored", {63'b0, control[0]}, 64'h1);
        rd(5'h16, rd_val); chk("restart_clr_pend", {32'b0, rd_val}, 64'h0);

        // Retrigger during DROP reloads the counter
        wr(5'h16, 32'h4);
        tick();
        wr(5'h16, 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reload_run%0d", i), {63'b0, control[0]}, 64'h0);
            tick();
        end
        chk("reload_restored", {63'b0, control[0]}, 64'h1);

        // Write during DROP takes effect at once
        wr(5'h16, 32'h4);
        wr(5'h12, 32'h7);
        chk("drop_wr_ctl", {45'b0, control}, 64'h6);
        repeat (4) tick();
        chk("drop_wr_after", {45'b0, control}, 64'h7);

`ifdef HASH_CYCLE_COUNTER_EN
        miner_irq = 1'b0;
        wr(5'h18, 32'h0);
        status = 7'h02;
        repeat (100) tick();
        status = 7'h00;
        rd(5'h18, rd_val); chk("hashcnt_100", {32'b0, rd_val}, 64'd100);
        rd(5'h19, rd_val); chk("hashcnt_100_hi", {32'b0, rd_val}, 64'd0);
        status = 7'h02;
        force dut.hashcnt_q = 64'hFFFFFFFF_FFFFFFFF;
        #1 release dut.hashcnt_q;
        tick();
        status = 7'h00;
        rd(5'h18, rd_val); chk("hashcnt_wrap_lo", {32'b0, rd_val}, 64'd0);
        rd(5'h19, rd_val); chk("hashcnt_wrap_hi", {32'b0, rd_val}, 64'd0);
`endif

        // Reset in the middle of DROP
        wr(5'h16, 32'h4);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_drop_ctl", {45'b0, control}, 64'h0);
        rst_n = 1'b1;
        tick();
        wr(5'h12, 32'h1);
        chk("rst_drop_idle", {45'b0, control}, 64'h1);
        chk("rst_drop_hdr", {32'b0, header[31:0]}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
